// File: rtl/sum_ascii_pkg.sv
// Shared constants, state encoding and helpers for the sum-to-ASCII formatter.
package sum_ascii_pkg;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_CR   = 8'h0D;

    localparam logic [8:0] DEC_100 = 9'd100;
    localparam logic [8:0] DEC_10  = 9'd10;

    // {cout,num_sum} is at most 9 bits wide, so 3 digits always suffice
    localparam int VAL_W      = 9;
    localparam int H_W        = 3;   // hundreds, max 5
    localparam int T_W        = 4;   // tens, max 9
    localparam int U_W        = 4;   // units, max 9
    localparam int MAX_CHARS  = 4;   // 3 digits + terminator
    localparam int IDX_W      = 2;
    localparam int CNT_W      = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_EMIT = 2'd2
    } state_t;

    // Map one decimal digit to its ASCII code
    function automatic logic [7:0] digit_char(input logic [3:0] d);
        return ASCII_ZERO + {4'h0, d};
    endfunction

endpackage

// File: rtl/bin_to_dec_seq.sv
// Repeated-subtraction binary to decimal engine: one subtraction per cycle,
// hundreds first, then tens. done is raised combinationally in the cycle the
// remainder drops below ten, with u presenting the units digit at that time.
module bin_to_dec_seq
    import sum_ascii_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [VAL_W-1:0] val,
    output logic             done,
    output logic [H_W-1:0]   h,
    output logic [T_W-1:0]   t,
    output logic [U_W-1:0]   u
);

    logic [VAL_W-1:0] rem;
    logic             running;

    // Load on start, then peel off one hundred or one ten per cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rem     <= '0;
            h       <= '0;
            t       <= '0;
            running <= 1'b0;
        end else if (start) begin
            rem     <= val;
            h       <= '0;
            t       <= '0;
            running <= 1'b1;
        end else if (running) begin
            if (rem >= DEC_100) begin
                rem <= rem - DEC_100;
                h   <= h + 3'd1;
            end else if (rem >= DEC_10) begin
                rem <= rem - DEC_10;
                t   <= t + 4'd1;
            end else begin
                running <= 1'b0;
            end
        end
    end

    assign done = running && (rem < DEC_10);
    assign u    = rem[U_W-1:0];

endmodule

// File: rtl/sum_ascii_formatter.sv
// Converts the adder result {cout,num_sum} into decimal ASCII characters with
// leading zeros suppressed, optionally followed by a terminator, streamed one
// character per valid/ready handshake.
module sum_ascii_formatter
    import sum_ascii_pkg::*;
#(
    parameter int         DATA_W    = 7,
    parameter int         TERM_EN   = 1,
    parameter logic [7:0] TERM_CHAR = 8'h0D
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] num_sum,
    input  logic              cout,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_char,
    output logic              out_last,
    output logic              busy
);

    state_t state, state_nxt;

    logic [VAL_W-1:0]               val_in;
    logic                           capture;
    logic                           done;
    logic [H_W-1:0]                 h;
    logic [T_W-1:0]                 t;
    logic [U_W-1:0]                 u;

    logic [MAX_CHARS-1:0][7:0]      chars, list_nxt;
    logic [IDX_W-1:0]               idx, last_idx;
    logic [CNT_W-1:0]               n_chars;
    logic [IDX_W-1:0]               last_nxt;
    logic                           fire, final_fire;

    // Zero-extend {cout,num_sum} into the 9-bit working value
    always_comb begin
        val_in             = '0;
        val_in[DATA_W:0]   = {cout, num_sum};
    end

    assign capture    = (state == ST_IDLE) && in_valid && in_ready;
    assign fire       = out_valid && out_ready;
    assign final_fire = fire && (idx == last_idx);

    bin_to_dec_seq u_conv (
        .clk   (clk),
        .rst_n (rst_n),
        .start (capture),
        .val   (val_in),
        .done  (done),
        .h     (h),
        .t     (t),
        .u     (u)
    );

    // Build the character list from the digits, dropping leading zeros only
    always_comb begin
        list_nxt = '0;
        n_chars  = '0;
        if (h != '0) begin
            list_nxt[0] = digit_char({1'b0, h});
            list_nxt[1] = digit_char(t);
            list_nxt[2] = digit_char(u);
            n_chars     = 3'd3;
        end else if (t != '0) begin
            list_nxt[0] = digit_char(t);
            list_nxt[1] = digit_char(u);
            n_chars     = 3'd2;
        end else begin
            list_nxt[0] = digit_char(u);
            n_chars     = 3'd1;
        end
        if (TERM_EN != 0) begin
            list_nxt[n_chars[IDX_W-1:0]] = TERM_CHAR;
            n_chars                      = n_chars + 3'd1;
        end
        last_nxt = IDX_W'(n_chars - 3'd1);
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (capture)    state_nxt = ST_CONV;
            ST_CONV: if (done)       state_nxt = ST_EMIT;
            ST_EMIT: if (final_fire) state_nxt = ST_IDLE;
            default:                 state_nxt = ST_IDLE;
        endcase
    end

    // Character buffer, emit pointer and the registered accept flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chars    <= '0;
            idx      <= '0;
            last_idx <= '0;
            in_ready <= 1'b0;
        end else begin
            in_ready <= (state_nxt == ST_IDLE);
            if (state == ST_CONV && done) begin
                chars    <= list_nxt;
                last_idx <= last_nxt;
                idx      <= '0;
            end else if (fire && !final_fire) begin
                idx <= idx + 2'd1;
            end
        end
    end

    // Output decode; char and last only depend on idx, so they hold while stalled
    always_comb begin
        out_valid = (state == ST_EMIT);
        busy      = (state != ST_IDLE);
        out_char  = out_valid ? chars[idx] : 8'h00;
        out_last  = out_valid && (idx == last_idx);
    end

    // Digit counters stay inside decimal range
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (h <= 3'd5) else $error("hundreds out of range");
            assert (t <= 4'd9) else $error("tens out of range");
        end
    end

endmodule

// File: tb/tb_sum_ascii_formatter.sv
module tb_sum_ascii_formatter;

    logic       clk = 0;
    logic       rst_n = 0;

    // DUT A: default build (7-bit sum, CR terminator)
    logic       in_valid = 0, in_ready, cout = 0, out_valid, out_ready = 0, out_last, busy;
    logic [6:0] num_sum = 0;
    logic [7:0] out_char;

    // DUT B: 8-bit sum, no terminator
    logic       b_in_valid = 0, b_in_ready, b_cout = 0, b_out_valid, b_out_ready = 1, b_out_last, b_busy;
    logic [7:0] b_num_sum = 0, b_out_char;

    sum_ascii_formatter #(.DATA_W(7), .TERM_EN(1), .TERM_CHAR(8'h0D)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .num_sum(num_sum), .cout(cout), .out_valid(out_valid), .out_ready(out_ready),
        .out_char(out_char), .out_last(out_last), .busy(busy));

    sum_ascii_formatter #(.DATA_W(8), .TERM_EN(0), .TERM_CHAR(8'h0D)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .num_sum(b_num_sum), .cout(b_cout), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_char(b_out_char), .out_last(b_out_last), .busy(b_busy));

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [8:0] exp_q[$];        // {last, char}
    int rdy_mode = 0;            // 0 always, 1 one-in-three, 2 random, 3 manual
    int rdy_k = 0;
    logic rst_q = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: decimal text of the value, then the terminator
    task automatic push_exp(input int v, input bit term);
        string s;
        s = $sformatf("%0d", v);
        for (int i = 0; i < s.len(); i++)
            exp_q.push_back({(!term && i == s.len() - 1), s[i]});
        if (term) exp_q.push_back({1'b1, 8'h0D});
    endtask

    // Consumer readiness
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0: out_ready = 1'b1;
            1: out_ready = (rdy_k % 3 == 0);
            2: out_ready = 1'($urandom_range(0, 1));
            default: ;
        endcase
        rdy_k++;
    end

    always @(posedge clk) rst_q <= rst_n;

    // Monitor / scoreboard
    logic stall_prev = 0, ready_next = 0, prev_last = 0;
    logic [7:0] prev_char = 0;
    always @(negedge clk) begin
        logic [8:0] e;
        if (!rst_q) begin
            chk("rst_out_valid", 32'(out_valid), 0);
            chk("rst_in_ready", 32'(in_ready), 0);
            chk("rst_out_char", 32'(out_char), 0);
            stall_prev = 0;
            ready_next = 0;
        end else begin
            if (ready_next) chk("in_ready_after_last", 32'(in_ready), 1);
            ready_next = 0;
            if (stall_prev) begin
                chk("stall_valid", 32'(out_valid), 1);
                chk("stall_char", 32'(out_char), 32'(prev_char));
                chk("stall_last", 32'(out_last), 32'(prev_last));
            end
            if (out_valid) chk("busy_in_emit", 32'(busy), 1);
            if (in_ready)  chk("busy_idle", 32'(busy), 0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    errors++; checks++;
                    $display("FAIL unexpected_char: got %0h expected none", out_char);
                end else begin
                    e = exp_q.pop_front();
                    chk("char", 32'(out_char), 32'(e[7:0]));
                    chk("last", 32'(out_last), 32'(e[8]));
                end
                if (out_last) ready_next = 1;
            end
            stall_prev = out_valid && !out_ready;
            prev_char  = out_char;
            prev_last  = out_last;
        end
    end

    // Issue one value to DUT A; optionally pulse in_valid while it is busy
    task automatic send(input int v, input bit pulse);
        int n;
        n = 0;
        while (!in_ready && n < 300) begin
            in_valid = pulse ? 1'($urandom_range(0, 1)) : 1'b0;
            {cout, num_sum} = 8'($urandom);
            @(posedge clk); #1;
            if (in_ready) in_valid = 0;
            n++;
        end
        if (!in_ready) begin
            errors++; checks++;
            $display("FAIL in_ready_timeout: got 0 expected 1");
            return;
        end
        in_valid = 1;
        {cout, num_sum} = 8'(v);
        push_exp(v, 1'b1);
        @(posedge clk); #1;
        in_valid = 0;
        n = 0;
        chk("busy_after_capture", 32'(busy), 1);
        while (!out_valid && n < 20) begin
            chk("busy_conv", 32'(busy), 1);
            @(posedge clk); #1;
            n++;
        end
        chk("latency", n, v / 100 + (v % 100) / 10 + 1);
    endtask

    task automatic run_b(input int v);
        string s;
        int n;
        n = 0;
        while (!b_in_ready && n < 50) begin @(posedge clk); #1; n++; end
        b_in_valid = 1;
        {b_cout, b_num_sum} = 9'(v);
        @(posedge clk); #1;
        b_in_valid = 0;
        s = $sformatf("%0d", v);
        for (int i = 0; i < s.len(); i++) begin
            n = 0;
            while (!b_out_valid && n < 20) begin @(posedge clk); #1; n++; end
            chk("b_char", 32'(b_out_char), 32'(s[i]));
            chk("b_last", 32'(b_out_last), 32'(i == s.len() - 1));
            @(posedge clk); #1;
        end
        chk("b_done_valid", 32'(b_out_valid), 0);
    endtask

    initial begin
        int n;
        // Reset hold with a pending request
        rst_n = 0; in_valid = 1; {cout, num_sum} = 8'h05;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready_hold", 32'(in_ready), 0);
        rst_n = 1;
        @(posedge clk); #1;
        chk("in_ready_release", 32'(in_ready), 1);
        chk("no_early_capture", 32'(busy), 0);
        send(5, 0);

        // Zero, maximum, internal zeros
        rdy_mode = 0;
        send(0, 0);
        send(255, 0);
        send(10, 0);
        send(100, 0);

        // Backpressure with spurious in_valid during emit
        rdy_mode = 1;
        send(128, 1);
        send(200, 1);

        // Randomized traffic
        for (int i = 0; i < 30; i++) begin
            rdy_mode = int'($urandom_range(0, 2));
            send(int'($urandom_range(0, 255)), 1);
        end

        // Reset in the middle of emit
        n = 0;
        while ((exp_q.size() != 0 || !in_ready) && n < 300) begin @(posedge clk); #1; n++; end
        rdy_mode = 3; out_ready = 0;
        send(255, 0);
        chk("mid_first_char", 32'(out_char), 32'h32);
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0; rst_n = 0;
        @(posedge clk); #1;
        chk("mid_rst_valid", 32'(out_valid), 0);
        exp_q.delete();
        rst_n = 1;
        rdy_mode = 0;
        send(42, 0);

        // TERM_EN=0, 8-bit build
        run_b(7);
        run_b(0);
        run_b(511);
        run_b(500);
        run_b(90);
        for (int i = 0; i < 5; i++) run_b(int'($urandom_range(0, 511)));

        n = 0;
        while ((exp_q.size() != 0 || !in_ready) && n < 300) begin @(posedge clk); #1; n++; end
        chk("queue_drained", exp_q.size(), 0);
        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
